// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: tag/valid array, bank RAM
// read/write sequencing and 4-beat line refill from the memory bus.
module icache_ctrl #(
    parameter int INDEX_SIZE = 8,
    parameter int TAG_SIZE   = 20,
    parameter int WORDS      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_valid,
    input  logic [31:0]             cpu_addr,
    output logic                    cpu_ready,
    output logic                    cpu_rvalid,
    output logic [31:0]             cpu_rdata,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_ack,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic                    bank_read_en,
    output logic [INDEX_SIZE-1:0]   bank_read_addr,
    input  logic [32*WORDS-1:0]     bank_read_data,
    output logic [WORDS-1:0]        bank_write_en,
    output logic [INDEX_SIZE-1:0]   bank_write_addr,
    output logic [31:0]             bank_write_data
);
    localparam int WSEL = $clog2(WORDS);
    localparam int OFF  = WSEL + 2;
    localparam int SETS = 1 << INDEX_SIZE;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MISS_REQ, REFILL, RETURN
    } state_t;

    state_t                state_q, state_d;
    logic [31:2]           addr_q, addr_d;
    logic                  lk_valid_q, lk_valid_d;
    logic [TAG_SIZE-1:0]   lk_tag_q, lk_tag_d;
    logic [WSEL-1:0]       beat_q, beat_d;
    logic [31:0]           word_q, word_d;
    logic [SETS-1:0]       valid_q;
    logic [TAG_SIZE-1:0]   tag_mem_q [SETS];
    logic                  tag_we;
    logic                  accept;

    logic [INDEX_SIZE-1:0] req_idx, cur_idx;
    logic [TAG_SIZE-1:0]   cur_tag;
    logic [WSEL-1:0]       cur_sel;
    logic                  hit;
    logic                  unused_addr;

    assign req_idx     = cpu_addr[OFF +: INDEX_SIZE];
    assign cur_idx     = addr_q[OFF +: INDEX_SIZE];
    assign cur_tag     = addr_q[OFF+INDEX_SIZE +: TAG_SIZE];
    assign cur_sel     = addr_q[2 +: WSEL];
    assign hit         = lk_valid_q && (lk_tag_q == cur_tag);
    assign unused_addr = ^cpu_addr[1:0];

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        lk_valid_d      = lk_valid_q;
        lk_tag_d        = lk_tag_q;
        beat_d          = beat_q;
        word_d          = word_q;
        tag_we          = 1'b0;
        accept          = 1'b0;
        cpu_ready       = 1'b0;
        cpu_rvalid      = 1'b0;
        cpu_rdata       = '0;
        mem_req         = 1'b0;
        mem_addr        = '0;
        bank_read_en    = 1'b0;
        bank_read_addr  = '0;
        bank_write_en   = '0;
        bank_write_addr = '0;
        bank_write_data = '0;

        unique case (state_q)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_valid) begin
                    accept  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = bank_read_data[cur_sel*32 +: 32];
                    cpu_ready  = 1'b1;
                    accept     = cpu_valid;
                    state_d    = cpu_valid ? LOOKUP : IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {cur_tag, cur_idx, {OFF{1'b0}}};
                if (mem_ack) begin
                    beat_d  = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (mem_rvalid) begin
                    bank_write_en   = WORDS'(1) << beat_q;
                    bank_write_addr = cur_idx;
                    bank_write_data = mem_rdata;
                    beat_d          = beat_q + 1'b1;
                    if (beat_q == cur_sel) word_d = mem_rdata;
                    if (beat_q == WSEL'(WORDS-1)) begin
                        tag_we  = 1'b1;
                        state_d = RETURN;
                    end
                end
            end
            RETURN: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = word_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            addr_d         = cpu_addr[31:2];
            bank_read_en   = 1'b1;
            bank_read_addr = req_idx;
            lk_valid_d     = valid_q[req_idx];
            lk_tag_d       = tag_mem_q[req_idx];
        end

        // Reset must silence every output, even mid-refill with beats arriving.
        if (reset) begin
            tag_we          = 1'b0;
            cpu_ready       = 1'b0;
            cpu_rvalid      = 1'b0;
            cpu_rdata       = '0;
            mem_req         = 1'b0;
            mem_addr        = '0;
            bank_read_en    = 1'b0;
            bank_read_addr  = '0;
            bank_write_en   = '0;
            bank_write_addr = '0;
            bank_write_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            lk_valid_q <= 1'b0;
            lk_tag_q   <= '0;
            beat_q     <= '0;
            word_q     <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lk_valid_q <= lk_valid_d;
            lk_tag_q   <= lk_tag_d;
            beat_q     <= beat_d;
            word_q     <= word_d;
            if (tag_we) valid_q[cur_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) tag_mem_q[cur_idx] <= cur_tag;
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction-cache controller that sits upstream of the icache data-bank RAMs: it accepts fetch requests from the CPU front end, keeps the tag/valid array, drives the bank read/write ports, and refills 16-byte lines from the memory bus on a miss. The cache has 256 sets of 4 words. Each word lives in its own bank RAM, which has a one-cycle registered read.

## Interface
- INDEX_SIZE, 8, set index width (address bits 11:4)
- TAG_SIZE, 20, tag width (address bits 31:12)
- WORDS, 4, words per line, one bank per word (address bits 3:2 select the word; bits 1:0 ignored)

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  single clock for all state
- reset  in  1  synchronous, active-high
- cpu_valid  in  1  fetch request
- cpu_addr  in  32  fetch byte address
- cpu_ready  out  1  request accepted this cycle when cpu_valid & cpu_ready
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid
- cpu_rdata  out  32  fetched instruction
- mem_req  out  1  line refill request
- mem_addr  out  32  line-aligned address {tag, index, 4'b0}
- mem_ack  in  1  bus accepted mem_req
- mem_rvalid  in  1  refill beat valid
- mem_rdata  in  32  refill beat, word 0 first
- bank_read_en  out  1  read all banks
- bank_read_addr  out  8  shared read index
- bank_read_data  in  128  {bank3..bank0} read data, one cycle after bank_read_en
- bank_write_en  out  4  one-hot bank write enable
- bank_write_addr  out  8  write index
- bank_write_data  out  32  write data

## Operation
- Tag/valid array: 256 entries × (1 valid + 20 tag) flops, held internally. Reset clears every valid bit in one cycle.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RETURN.
- IDLE:
  - cpu_ready=1.
  - On cpu_valid, latch the address, drive bank_read_en=1 and bank_read_addr=cpu_addr[11:4], read the tag entry, then go to LOOKUP.
- LOOKUP: hit means the latched valid bit is set and the stored tag equals latched addr[31:12].
  - Hit, part 1: cpu_rvalid=1 and cpu_rdata = bank_read_data word addr[3:2].
  - Hit, part 2: cpu_ready=1 in the same cycle. A new cpu_valid is accepted exactly as in IDLE and the FSM stays in LOOKUP; with no new request, the FSM goes to IDLE.
  - Miss: cpu_ready=0, cpu_rvalid=0, go to MISS_REQ.
- MISS_REQ:
  - mem_req=1 and mem_addr = {tag, index, 4'b0}, held stable until mem_ack.
  - On mem_ack, clear the beat counter and go to REFILL.
- REFILL: each mem_rvalid beat k (k = 0..3) does the following:
  - Asserts bank_write_en = 1<<k, with bank_write_addr=index and bank_write_data=mem_rdata.
  - If k == addr[3:2], latches mem_rdata as the result.
  - On beat 3, also writes tag and sets valid for the index on the same edge, then goes to RETURN.
- RETURN: cpu_rvalid=1 and cpu_rdata = latched word, then go to IDLE. cpu_ready=0.
- Rules that hold in every state:
  - cpu_ready=0 in MISS_REQ, REFILL and RETURN. cpu_valid is ignored there.
  - mem_rvalid outside REFILL is ignored.
  - Gaps between beats are allowed; the counter advances only on mem_rvalid.
  - Banks are never read and written in the same cycle: reads happen only on IDLE/LOOKUP acceptance; writes happen only in REFILL.

## Timing
- Reset values:
  - state=IDLE, all valid bits 0, beat counter 0.
  - cpu_ready=0 during the reset cycle, then 1 in IDLE.
  - cpu_rvalid=0, cpu_rdata=0.
  - mem_req=0, mem_addr=0.
  - bank_read_en=0, bank_write_en=0, and all other bank outputs 0.
- Hit latency: request accepted at edge T, cpu_rvalid high in cycle T+1. Back-to-back hits sustain one fetch per cycle.
- Miss latency: 1 (lookup) + mem_ack wait + 4 beats + 1 (RETURN). With mem_ack in the first MISS_REQ cycle and beats every cycle, cpu_rvalid rises 7 cycles after acceptance.
- A refilled line is readable by a request accepted in the cycle after RETURN. Tag and valid are already updated at that point, so the access hits.
- Reset in any state (including mid-refill):
  - Returns to IDLE next cycle and clears the valid bits.
  - Drops mem_req. No cpu_rvalid is produced for the aborted request.
  - Late beats from the aborted refill are ignored.
- A miss on a valid index with a different tag overwrites the line; no write-back occurs.

## Test plan
- Cold miss:
  - Stimulus: after reset, fetch 0x0000_1008; mem_ack immediate; beats 0xA0,0xA1,0xA2,0xA3.
  - Response: mem_addr=0x0000_1000; bank_write_en 0001,0010,0100,1000 at index 0x00; cpu_rvalid with cpu_rdata=0xA2 seven cycles after acceptance.
- Hit stream: fetch 0x1000, 0x1004, 0x100C back-to-back after the cold fill -> cpu_rvalid on three consecutive cycles with 0xA0, 0xA1, 0xA3; mem_req stays 0.
- Conflict miss: fetch 0x0000_2008 (same index, tag 0x2) -> refill from 0x0000_2000; a subsequent fetch of 0x1008 misses again.
- Stalled bus:
  - Stimulus: mem_ack delayed 3 cycles; idle gap between beats 1 and 2; cpu_valid held high throughout.
  - Response: mem_addr stable while waiting; cpu_ready=0 until RETURN completes; correct word returned.
- Reset mid-refill:
  - Stimulus: assert reset after beat 1; then drive beats 2 and 3.
  - Response: the late beats produce no bank writes; the next fetch to the same line misses.
- Reset state: during and after reset, every output matches its listed reset value; a fetch to any address misses.
